// File: rtl/lru_victim_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lru_victim_ctrl: true-LRU replacement and victim sequencer, 4-way cache  |
// | Optional eviction statistics counter: define LRU_STATS_EN                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lru_victim_ctrl #(
  parameter int NSETS = 8,
  parameter int SET_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             touch_v,
  input  logic [SET_W-1:0] touch_set,
  input  logic [3:0]       touch_way,
  input  logic             inval_v,
  input  logic [SET_W-1:0] inval_set,
  input  logic [3:0]       inval_way,
  input  logic             alloc_v,
  input  logic [SET_W-1:0] alloc_set,
  output logic             alloc_rdy,
  output logic             vict_v,
  output logic [SET_W-1:0] vict_set,
  output logic [3:0]       vict_way,
  output logic             vict_dirty_evict,
  input  logic             fill_done,
  input  logic             fill_abort,
  output logic [15:0]      evict_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [7:0] RANK_RST = 8'b00_01_10_11;

  state_t                   r_state, w_state_nxt;
  logic                     r_sel_phase, w_sel_phase_nxt;
  logic [SET_W-1:0]         r_alloc_set;
  logic [NSETS-1:0][3:0]    r_valid, w_valid_nxt;
  logic [NSETS-1:0][7:0]    r_rank, w_rank_nxt;
  logic [SET_W-1:0]         r_vict_set;
  logic [3:0]               r_vict_way;
  logic                     r_vict_dirty;
  logic [3:0]               w_cur_valid;
  logic [7:0]               w_cur_rank;
  logic [3:0]               w_vict_way;
  logic                     w_fill, w_inval_ok, w_touch_ok, w_touch_drop, w_sel_done;

  function automatic logic f_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] f_rank_of(input logic [7:0] rk, input logic [3:0] w);
    logic [1:0] rw;
    rw = 2'd0;
    for (int j = 0; j < 4; j++)
      if (w[j]) rw = rk[2*j +: 2];
    return rw;
  endfunction

  function automatic logic [7:0] f_touch(input logic [7:0] rk, input logic [3:0] w);
    logic [1:0] rw;
    logic [7:0] o;
    rw = f_rank_of(rk, w);
    o  = rk;
    for (int j = 0; j < 4; j++) begin
      if (w[j])                   o[2*j +: 2] = 2'd0;
      else if (rk[2*j +: 2] < rw) o[2*j +: 2] = rk[2*j +: 2] + 2'd1;
    end
    return o;
  endfunction

  function automatic logic [7:0] f_inval(input logic [7:0] rk, input logic [3:0] w);
    logic [1:0] rw;
    logic [7:0] o;
    rw = f_rank_of(rk, w);
    o  = rk;
    for (int j = 0; j < 4; j++) begin
      if (w[j])                   o[2*j +: 2] = 2'd3;
      else if (rk[2*j +: 2] > rw) o[2*j +: 2] = rk[2*j +: 2] - 2'd1;
    end
    return o;
  endfunction

  assign w_fill       = (r_state == HOLD) && fill_done && !fill_abort;
  assign w_inval_ok   = inval_v && f_onehot(inval_way);
  assign w_touch_ok   = touch_v && f_onehot(touch_way);
  assign w_touch_drop = w_inval_ok && (inval_set == touch_set) && (inval_way == touch_way);
  assign w_sel_done   = (r_state == SELECT) && r_sel_phase;

  // Per-set update order: invalidate, then touch, then the fill's MRU touch.
  always_comb begin
    w_valid_nxt = r_valid;
    w_rank_nxt  = r_rank;
    for (int s = 0; s < NSETS; s++) begin
      if (w_inval_ok && (inval_set == SET_W'(s))) begin
        w_valid_nxt[s] = w_valid_nxt[s] & ~inval_way;
        w_rank_nxt[s]  = f_inval(w_rank_nxt[s], inval_way);
      end
      if (w_touch_ok && !w_touch_drop && (touch_set == SET_W'(s)))
        w_rank_nxt[s] = f_touch(w_rank_nxt[s], touch_way);
      if (w_fill && (r_vict_set == SET_W'(s))) begin
        w_valid_nxt[s] = w_valid_nxt[s] | r_vict_way;
        w_rank_nxt[s]  = f_touch(w_rank_nxt[s], r_vict_way);
      end
    end
  end

  assign w_cur_valid = r_valid[r_alloc_set];
  assign w_cur_rank  = r_rank[r_alloc_set];

  always_comb begin
    w_vict_way = 4'd0;
    if (&w_cur_valid) begin
      for (int j = 0; j < 4; j++)
        if (w_cur_rank[2*j +: 2] == 2'd3) w_vict_way[j] = 1'b1;
    end else begin
      for (int j = 3; j >= 0; j--)
        if (!w_cur_valid[j]) w_vict_way = 4'd1 << j;
    end
  end

  // SELECT spans two cycles so the victim lands two edges after acceptance.
  always_comb begin
    w_state_nxt     = r_state;
    w_sel_phase_nxt = r_sel_phase;
    alloc_rdy       = 1'b0;
    vict_v          = 1'b0;
    case (r_state)
      IDLE: begin
        alloc_rdy = 1'b1;
        if (alloc_v) begin
          w_state_nxt     = SELECT;
          w_sel_phase_nxt = 1'b0;
        end
      end
      SELECT: begin
        if (r_sel_phase) w_state_nxt = HOLD;
        else             w_sel_phase_nxt = 1'b1;
      end
      HOLD: begin
        vict_v = 1'b1;
        if (fill_done || fill_abort) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_sel_phase  <= 1'b0;
      r_alloc_set  <= '0;
      r_valid      <= '0;
      r_rank       <= {NSETS{RANK_RST}};
      r_vict_set   <= '0;
      r_vict_way   <= 4'd0;
      r_vict_dirty <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel_phase <= w_sel_phase_nxt;
      r_valid     <= w_valid_nxt;
      r_rank      <= w_rank_nxt;
      if ((r_state == IDLE) && alloc_v) r_alloc_set <= alloc_set;
      if (w_sel_done) begin
        r_vict_set   <= r_alloc_set;
        r_vict_way   <= w_vict_way;
        r_vict_dirty <= &w_cur_valid;
      end
    end
  end

  assign vict_set         = r_vict_set;
  assign vict_way         = r_vict_way;
  assign vict_dirty_evict = r_vict_dirty;

`ifdef LRU_STATS_EN
  logic [15:0] r_evict_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_evict_cnt <= 16'd0;
    else if (w_fill && r_vict_dirty && (r_evict_cnt != 16'hFFFF))
      r_evict_cnt <= r_evict_cnt + 16'd1;
  end

  assign evict_cnt = r_evict_cnt;
`else
  assign evict_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lru_victim_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lru_victim_ctrl: randomized bench with a recency-list reference model |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_lru_victim_ctrl;

  localparam int NSETS = 8;
  localparam int SET_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             touch_v = 1'b0, inval_v = 1'b0, alloc_v = 1'b0;
  logic [SET_W-1:0] touch_set = '0, inval_set = '0, alloc_set = '0;
  logic [3:0]       touch_way = '0, inval_way = '0;
  logic             fill_done = 1'b0, fill_abort = 1'b0;
  logic             alloc_rdy, vict_v, vict_dirty_evict;
  logic [SET_W-1:0] vict_set;
  logic [3:0]       vict_way;
  logic [15:0]      evict_cnt;

  lru_victim_ctrl #(.NSETS(NSETS), .SET_W(SET_W)) dut (
    .clk(clk), .rst(rst),
    .touch_v(touch_v), .touch_set(touch_set), .touch_way(touch_way),
    .inval_v(inval_v), .inval_set(inval_set), .inval_way(inval_way),
    .alloc_v(alloc_v), .alloc_set(alloc_set), .alloc_rdy(alloc_rdy),
    .vict_v(vict_v), .vict_set(vict_set), .vict_way(vict_way),
    .vict_dirty_evict(vict_dirty_evict),
    .fill_done(fill_done), .fill_abort(fill_abort), .evict_cnt(evict_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: each set keeps its ways as a recency list, MRU first.
  int        m_order [NSETS][$];
  bit [3:0]  m_valid [NSETS];
  int        m_vset;
  bit [3:0]  m_vway;
  bit        m_vdirty;
  int        m_evict;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int m_idx(input bit [3:0] w);
    for (int i = 0; i < 4; i++) if (w[i]) return i;
    return 0;
  endfunction

  function automatic void m_remove(input int s, input int w);
    for (int i = 0; i < m_order[s].size(); i++)
      if (m_order[s][i] == w) begin
        m_order[s].delete(i);
        break;
      end
  endfunction

  function automatic void m_touch(input int s, input int w);
    m_remove(s, w);
    m_order[s].push_front(w);
  endfunction

  function automatic void m_inval(input int s, input int w);
    m_valid[s][w] = 1'b0;
    m_remove(s, w);
    m_order[s].push_back(w);
  endfunction

  function automatic void m_reset();
    for (int s = 0; s < NSETS; s++) begin
      m_valid[s] = 4'd0;
      m_order[s].delete();
      for (int w = 3; w >= 0; w--) m_order[s].push_back(w);
    end
    m_evict = 0;
  endfunction

  function automatic logic [7:0] m_rank_vec(input int s);
    logic [7:0] r;
    r = 8'd0;
    for (int i = 0; i < 4; i++) r[2*m_order[s][i] +: 2] = 2'(i);
    return r;
  endfunction

  function automatic bit [3:0] m_victim(input int s);
    if (m_valid[s] != 4'hF) begin
      for (int w = 0; w < 4; w++) if (!m_valid[s][w]) return 4'd1 << w;
    end
    return 4'd1 << m_order[s][3];
  endfunction

  function automatic void m_apply(input bit do_fill);
    bit iok, tok;
    iok = inval_v && $onehot(inval_way);
    tok = touch_v && $onehot(touch_way) &&
          !(iok && (inval_set == touch_set) && (inval_way == touch_way));
    if (iok) m_inval(int'(inval_set), m_idx(inval_way));
    if (tok) m_touch(int'(touch_set), m_idx(touch_way));
    if (do_fill) begin
      m_valid[m_vset] = m_valid[m_vset] | m_vway;
      m_touch(m_vset, m_idx(m_vway));
`ifdef LRU_STATS_EN
      if (m_vdirty && (m_evict != 32'hFFFF)) m_evict++;
`endif
    end
  endfunction

  function automatic logic [3:0] rnd_way();
    if ($urandom_range(3) == 0) return 4'($urandom);
    return 4'd1 << $urandom_range(3);
  endfunction

  task automatic traffic(input int s);
    touch_v   = 1'($urandom_range(1));
    touch_set = ($urandom_range(1) == 1) ? SET_W'(s) : SET_W'($urandom_range(NSETS-1));
    touch_way = rnd_way();
    inval_v   = ($urandom_range(9) == 0);
    inval_set = ($urandom_range(1) == 1) ? SET_W'(s) : SET_W'($urandom_range(NSETS-1));
    inval_way = rnd_way();
    if ($urandom_range(7) == 0) begin
      inval_set = touch_set;
      inval_way = touch_way;
    end
  endtask

  task automatic cycle(input bit fd, input bit fa, input bit in_hold);
    m_apply(in_hold && fd && !fa);
    @(posedge clk);
    #1;
    touch_v    = 1'b0;
    inval_v    = 1'b0;
    fill_done  = 1'b0;
    fill_abort = 1'b0;
  endtask

  task automatic check_state();
    for (int s = 0; s < NSETS; s++) begin
      check($sformatf("valid[%0d]", s), dut.r_valid[s], m_valid[s]);
      check($sformatf("rank[%0d]", s), dut.r_rank[s], m_rank_vec(s));
    end
  endtask

  task automatic start_alloc(input int s, input bit traf);
    bit [3:0] ev;
    bit       ed;
    check("rdy_idle", alloc_rdy, 1);
    alloc_v   = 1'b1;
    alloc_set = SET_W'(s);
    if (traf) traffic(s);
    cycle(1'b0, 1'b0, 1'b0);
    alloc_v = 1'b0;
    check("rdy_select", alloc_rdy, 0);
    check("vv_select", vict_v, 0);
    if (traf) traffic(s);
    cycle(1'b0, 1'b0, 1'b0);
    check("vv_select2", vict_v, 0);
    ev = m_victim(s);
    ed = (m_valid[s] == 4'hF);
    if (traf) traffic(s);
    cycle(1'b0, 1'b0, 1'b0);
    check("vv_hold", vict_v, 1);
    check("vict_way", vict_way, ev);
    check("vict_set", vict_set, s);
    check("vict_dirty", vict_dirty_evict, ed);
    m_vset   = s;
    m_vway   = ev;
    m_vdirty = ed;
  endtask

  task automatic finish_alloc(input int nhold, input int outcome, input bit traf);
    bit fd, fa;
    repeat (nhold) begin
      if (traf) traffic(m_vset);
      cycle(1'b0, 1'b0, 1'b1);
      check("vv_held", vict_v, 1);
      check("way_held", vict_way, m_vway);
    end
    fd = (outcome != 1);
    fa = (outcome != 0);
    fill_done  = fd;
    fill_abort = fa;
    if (traf) traffic(m_vset);
    cycle(fd, fa, 1'b1);
    check("vv_end", vict_v, 0);
    check("rdy_end", alloc_rdy, 1);
    check("evict_cnt", evict_cnt, m_evict);
    check_state();
  endtask

  task automatic do_alloc(input int s, input int nhold, input int outcome, input bit traf);
    start_alloc(s, traf);
    finish_alloc(nhold, outcome, traf);
  endtask

  initial begin
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", alloc_rdy, 1);
    check("rst_vv", vict_v, 0);
    check("rst_way", vict_way, 0);
    check("rst_cnt", evict_cnt, 0);
    rst = 1'b1;
    check_state();

    // Cold fill of set 2
    start_alloc(2, 1'b0);
    check("t1_way", vict_way, 4'b0001);
    check("t1_dirty", vict_dirty_evict, 0);
    finish_alloc(0, 0, 1'b0);
    check("t1_valid", dut.r_valid[2], 4'b0001);
    check("t1_rank", dut.r_rank[2], 8'b01_10_11_00);

    // Fill set 5, touch way0, then evict the LRU way
    for (int i = 0; i < 4; i++) begin
      start_alloc(5, 1'b0);
      check("t2_fill_way", vict_way, 4'd1 << i);
      finish_alloc(1, 0, 1'b0);
    end
    touch_v = 1'b1; touch_set = 3'd5; touch_way = 4'b0001;
    cycle(1'b0, 1'b0, 1'b0);
    start_alloc(5, 1'b0);
    check("t2_way", vict_way, 4'b0010);
    check("t2_dirty", vict_dirty_evict, 1);
    finish_alloc(0, 0, 1'b0);
`ifdef LRU_STATS_EN
    check("t2_cnt", evict_cnt, 1);
`endif

    // Touch of the held victim, then abort
    start_alloc(3, 1'b0);
    touch_v = 1'b1; touch_set = 3'd3; touch_way = 4'b0001;
    cycle(1'b0, 1'b0, 1'b1);
    check("t3_way", vict_way, 4'b0001);
    finish_alloc(0, 1, 1'b0);
    check("t3_valid", dut.r_valid[3], 4'b0000);

    // Same-cycle invalidate and touch of one way
    for (int i = 0; i < 4; i++) do_alloc(1, 0, 0, 1'b0);
    touch_v = 1'b1; touch_set = 3'd1; touch_way = 4'b0100;
    inval_v = 1'b1; inval_set = 3'd1; inval_way = 4'b0100;
    cycle(1'b0, 1'b0, 1'b0);
    check("t4_valid", dut.r_valid[1], 4'b1011);
    check("t4_rank2", dut.r_rank[1][5:4], 2'd3);
    start_alloc(1, 1'b0);
    check("t4_way", vict_way, 4'b0100);
    check("t4_dirty", vict_dirty_evict, 0);
    finish_alloc(0, 0, 1'b0);

    // fill_done with fill_abort: abort wins
    do_alloc(5, 1, 2, 1'b0);

    // Asynchronous reset during HOLD
    start_alloc(4, 1'b0);
    #2 rst = 1'b0;
    #1;
    m_reset();
    check("rr_vv", vict_v, 0);
    check("rr_rdy", alloc_rdy, 1);
    check("rr_way", vict_way, 0);
    check("rr_cnt", evict_cnt, 0);
    check_state();
    @(posedge clk);
    #1 rst = 1'b1;
    start_alloc(0, 1'b0);
    check("rr_way0", vict_way, 4'b0001);
    finish_alloc(0, 0, 1'b0);

    // Randomized traffic around allocations
    for (int n = 0; n < 150; n++) begin
      int idle;
      int oc;
      idle = $urandom_range(3);
      repeat (idle) begin
        traffic($urandom_range(NSETS-1));
        fill_done  = 1'($urandom_range(1));
        fill_abort = 1'($urandom_range(1));
        cycle(fill_done, fill_abort, 1'b0);
        check("idle_vv", vict_v, 0);
      end
      oc = $urandom_range(9);
      do_alloc($urandom_range(NSETS-1), $urandom_range(3),
               (oc < 7) ? 0 : ((oc < 9) ? 1 : 2), 1'b1);
    end

`ifdef LRU_STATS_EN
    // Saturation: preload near the top, then evict past it
    for (int i = 0; i < 4; i++) do_alloc(6, 0, 0, 1'b0);
    force dut.r_evict_cnt = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.r_evict_cnt;
    m_evict = 32'hFFFE;
    do_alloc(6, 0, 0, 1'b0);
    do_alloc(6, 0, 0, 1'b0);
    check("sat_cnt", evict_cnt, 16'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lru_victim_ctrl.md
Name: lru_victim_ctrl

Overview:
- Replacement controller for the 4-way set-associative cache in the M stage.
- Holds per-set true-LRU rank state and valid bits.
- Shares that state between three requesters: the hit-touch path, the miss-allocate path and the invalidate path.
- Sequences each miss allocation: accept, select victim, hold the victim until the fill completes or aborts.

Parameters:
- NSETS, 8, number of cache sets.
- SET_W, 3, set index width; equals log2(NSETS).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- touch_v  in  1  hit-touch request; single cycle, no handshake, always accepted.
- touch_set  in  SET_W  set index for the touch.
- touch_way  in  4  one-hot way that hit.
- inval_v  in  1  invalidate request; always accepted.
- inval_set  in  SET_W  set index for the invalidate.
- inval_way  in  4  one-hot way to invalidate.
- alloc_v  in  1  allocation request.
- alloc_set  in  SET_W  set needing a victim.
- alloc_rdy  out  1  controller can accept an allocation.
- vict_v  out  1  victim valid.
- vict_set  out  SET_W  set of the held victim.
- vict_way  out  4  one-hot victim way.
- vict_dirty_evict  out  1  victim way was valid, i.e. an eviction rather than a cold fill.
- fill_done  in  1  fill of the victim completed.
- fill_abort  in  1  fill cancelled.
- evict_cnt  out  16  eviction statistic (see Optional Feature).

Behaviour:
- Per-set state
  - valid[3:0].
  - rank[w] (2 bits each) per way: 0 = MRU, 3 = LRU.
  - Ranks within a set are always a permutation of {0,1,2,3}.
- Reset (rst low, asynchronous)
  - All valid = 0.
  - Ranks per set: way0 = 3, way1 = 2, way2 = 1, way3 = 0.
  - FSM to IDLE.
  - Outputs: alloc_rdy = 1, vict_v = 0, vict_set = 0, vict_way = 0, vict_dirty_evict = 0, evict_cnt = 0.
  - Reset mid-allocation discards the allocation; no partial state update.
- Touch(set, w)
  - Every way with rank < rank[w] increments; rank[w] becomes 0.
  - A non-one-hot touch_way is ignored.
- Invalidate(set, w)
  - valid[w] becomes 0.
  - Every way with rank > rank[w] decrements; rank[w] becomes 3.
  - A non-one-hot inval_way is ignored.
- Same-cycle ordering, per set
  - Invalidate applies first, then touch, then fill_done's MRU update.
  - A touch to the same set and same way as a same-cycle invalidate is dropped.
  - Updates to different sets apply independently in the same cycle.
- FSM
  - IDLE: alloc_rdy = 1. alloc_v high latches alloc_set and goes to SELECT.
  - SELECT: alloc_rdy = 0.
    - Victim is the lowest-index way with valid = 0; if all ways are valid, the way with rank 3.
    - Registers vict_way, vict_set, and vict_dirty_evict (= all ways valid).
    - Goes to HOLD.
  - HOLD: vict_v = 1; vict_way and vict_set are stable.
    - fill_done: set valid[victim], touch victim (MRU), go to IDLE.
    - fill_abort: no state change, go to IDLE.
    - fill_done and fill_abort together: abort wins.
    - fill_done and fill_abort in IDLE or SELECT are ignored.
  - Victim is not recomputed if touches or invalidates hit the held set during HOLD.
  - An invalidate of the held victim during HOLD is still honoured; fill_done then re-validates the way.
- Latency
  - Allocation accepted at edge N gives vict_v = 1 after edge N+2.
  - vict_v drops after the edge on which fill_done or fill_abort is sampled.
  - alloc_rdy returns to 1 in that same cycle.
- Back-to-back allocation: the earliest next acceptance is the edge after the IDLE return; no pipelining of allocations.

Optional Feature:
- Macro: LRU_STATS_EN.
- Defined:
  - evict_cnt is a 16-bit saturating counter, incremented on each fill_done whose held vict_dirty_evict = 1.
  - Holds at 16'hFFFF once saturated.
  - Cleared by reset.
- Undefined: evict_cnt is driven constant 0 and no counter logic exists.

Test Plan:
- Reset then alloc set 2 → vict_v two cycles later, vict_way = 4'b0001, vict_dirty_evict = 0; fill_done → set 2 valid = 4'b0001, rank way0 = 0, way1 = 3, way2 = 2, way3 = 1.
- Fill all 4 ways of set 5 (victims in order 0001, 0010, 0100, 1000); touch way 4'b0001; alloc set 5 → victim 4'b0010, vict_dirty_evict = 1; with LRU_STATS_EN, evict_cnt = 1 after fill_done.
- In HOLD on set 3, touch set 3 way equal to victim → vict_way unchanged; fill_abort → valid unchanged, alloc_rdy = 1 next cycle.
- Same cycle: inval set 1 way 4'b0100 plus touch set 1 way 4'b0100 → valid[2] = 0, rank[2] = 3, touch dropped; next alloc set 1 → victim 4'b0100, vict_dirty_evict = 0.
- Assert rst low during HOLD → vict_v = 0 and alloc_rdy = 1 immediately, all valid = 0; rst release then alloc set 0 → victim 4'b0001.
- fill_done and fill_abort high together in HOLD → no valid/rank change, FSM to IDLE; with LRU_STATS_EN, 65536 evictions → evict_cnt = 16'hFFFF.
